// File: rtl/audio_env_pkg.sv
// Shared types and constants for the audio envelope stage.
// Provides the envelope state encoding, gain/sample widths and the
// gain-scaling helper that both output channels use.
package audio_env_pkg;

    localparam int GAIN_W   = 9;
    localparam int GAIN_MAX = 256;
    localparam int SAMPLE_W = 16;
    localparam int DIV_W    = 22;

    // Encoding is visible on env_state, so the values are fixed.
    typedef enum logic [1:0] {
        ENV_SILENT  = 2'd0,
        ENV_ATTACK  = 2'd1,
        ENV_SUSTAIN = 2'd2,
        ENV_RELEASE = 2'd3
    } env_state_e;

    // (s * g) >>> 8 with g in 0..256; the product never exceeds the sample
    // range, so bits [23:8] are the arithmetically shifted result.
    function automatic logic [SAMPLE_W-1:0] scale_sample(
        input logic signed [SAMPLE_W-1:0] s,
        input logic        [GAIN_W-1:0]   g
    );
        logic signed [SAMPLE_W+GAIN_W:0] p;
        p = s * $signed({1'b0, g});
        return p[SAMPLE_W+7:8];
    endfunction

endpackage

// File: rtl/env_tick_gen.sv
// Free-running prescaler for the envelope: counts 0..TICK_DIV-1 and
// pulses tick for one cycle while the count sits at TICK_DIV-1.
module env_tick_gen #(
    parameter int TICK_DIV = 100000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Wrap at the last count; never restarted by note activity.
    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + ONE;
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/audio_envelope.sv
// Attack/release envelope between the tone generator and the I2S
// serializer. Scales both channels by a 0..256 gain that ramps up when a
// note starts and down when the note changes or stops.
// Optional build macro SUSTAIN_DECAY_EN: in SUSTAIN the gain decays by one
// per tick down to SUSTAIN_FLOOR instead of holding at unity.
module audio_envelope
    import audio_env_pkg::*;
#(
    parameter int TICK_DIV      = 100000,
    parameter int ATK_STEP      = 8,
    parameter int REL_STEP      = 16,
    parameter int SUSTAIN_FLOOR = 128
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DIV_W-1:0]    note_div_left,
    input  logic [DIV_W-1:0]    note_div_right,
    input  logic [SAMPLE_W-1:0] audio_left_in,
    input  logic [SAMPLE_W-1:0] audio_right_in,
    output logic [SAMPLE_W-1:0] audio_left,
    output logic [SAMPLE_W-1:0] audio_right,
    output logic [1:0]          env_state
);

    localparam logic [GAIN_W:0]   ATK_W   = (GAIN_W + 1)'(ATK_STEP);
    localparam logic [GAIN_W:0]   REL_W   = (GAIN_W + 1)'(REL_STEP);
    localparam logic [GAIN_W:0]   G_MAX_W = (GAIN_W + 1)'(GAIN_MAX);
    localparam logic [GAIN_W-1:0] G_MAX   = GAIN_W'(GAIN_MAX);
    localparam logic [GAIN_W-1:0] FLOOR_G = GAIN_W'(SUSTAIN_FLOOR);
    localparam logic [GAIN_W-1:0] G_ONE   = GAIN_W'(1);
`ifdef SUSTAIN_DECAY_EN
    localparam bit DECAY_EN = 1'b1;
`else
    localparam bit DECAY_EN = 1'b0;
`endif

    env_state_e          state_q, state_d;
    logic [GAIN_W-1:0]   gain_q, gain_d;
    logic [DIV_W-1:0]    prev_l_q, prev_r_q;
    logic [SAMPLE_W-1:0] out_l_q, out_r_q, out_l_d, out_r_d;
    logic                tick, chg, active;
    logic [GAIN_W:0]     atk_sum;
    logic [GAIN_W-1:0]   gain_up, gain_dn;

    env_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick)
    );

    // Note-change / activity detection and saturated ramp candidates.
    always_comb begin
        chg     = (note_div_left != prev_l_q) || (note_div_right != prev_r_q);
        active  = (note_div_left != '0) || (note_div_right != '0);
        atk_sum = {1'b0, gain_q} + ATK_W;
        gain_up = (atk_sum >= G_MAX_W) ? G_MAX : atk_sum[GAIN_W-1:0];
        gain_dn = ({1'b0, gain_q} <= REL_W) ? '0 : gain_q - REL_W[GAIN_W-1:0];
    end

    // Envelope FSM; a change outranks a coincident tick in ATTACK/SUSTAIN,
    // and RELEASE ignores changes until the gain reaches zero.
    always_comb begin
        state_d = state_q;
        gain_d  = gain_q;
        case (state_q)
            ENV_SILENT: begin
                gain_d = '0;
                if (chg && active) state_d = ENV_ATTACK;
            end
            ENV_ATTACK: begin
                if (chg) begin
                    state_d = ENV_RELEASE;
                end else if (tick) begin
                    gain_d = gain_up;
                    if (gain_up == G_MAX) state_d = ENV_SUSTAIN;
                end
            end
            ENV_SUSTAIN: begin
                if (chg) begin
                    state_d = ENV_RELEASE;
                end else if (DECAY_EN && tick && (gain_q > FLOOR_G)) begin
                    gain_d = gain_q - G_ONE;
                end
            end
            ENV_RELEASE: begin
                if (tick) begin
                    gain_d = gain_dn;
                    if (gain_dn == '0) state_d = active ? ENV_ATTACK : ENV_SILENT;
                end
            end
            default: begin
                state_d = ENV_SILENT;
                gain_d  = '0;
            end
        endcase
    end

    // Sample scaling with the gain in effect during the input cycle.
    always_comb begin
        out_l_d = scale_sample($signed(audio_left_in), gain_q);
        out_r_d = scale_sample($signed(audio_right_in), gain_q);
    end

    // State, gain, divisor history and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ENV_SILENT;
            gain_q   <= '0;
            prev_l_q <= '0;
            prev_r_q <= '0;
            out_l_q  <= '0;
            out_r_q  <= '0;
        end else begin
            state_q  <= state_d;
            gain_q   <= gain_d;
            prev_l_q <= note_div_left;
            prev_r_q <= note_div_right;
            out_l_q  <= out_l_d;
            out_r_q  <= out_r_d;
        end
    end

    assign audio_left  = out_l_q;
    assign audio_right = out_r_q;
    assign env_state   = state_q;

endmodule

// File: tb/tb_audio_envelope.sv
// Randomized bench for audio_envelope with a short tick period. Two
// instances (default attack step and ATK_STEP=7) share all stimulus and
// are compared every cycle against a behavioural model of the envelope.
module tb_audio_envelope;

    localparam int TD = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [21:0] ndl = '0, ndr = '0;
    logic [15:0] inl = '0, inr = '0;
    logic [15:0] outl0, outr0, outl1, outr1;
    logic [1:0]  st0, st1;

    int errors = 0;
    int checks = 0;

    audio_envelope #(.TICK_DIV(TD)) dut (
        .clk(clk), .rst_n(rst_n),
        .note_div_left(ndl), .note_div_right(ndr),
        .audio_left_in(inl), .audio_right_in(inr),
        .audio_left(outl0), .audio_right(outr0), .env_state(st0)
    );

    audio_envelope #(.TICK_DIV(TD), .ATK_STEP(7)) dut7 (
        .clk(clk), .rst_n(rst_n),
        .note_div_left(ndl), .note_div_right(ndr),
        .audio_left_in(inl), .audio_right_in(inr),
        .audio_left(outl1), .audio_right(outr1), .env_state(st1)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // States as plain numbers: 0 silent, 1 attack, 2 sustain, 3 release.
    int atk[2] = '{8, 7};
    int m_st[2], m_g[2], m_ol[2], m_or[2];
    int m_pl, m_pr, m_tc;

    function automatic int scale(input logic [15:0] s, input int g);
        int v;
        v = int'($signed(s)) * g;
        return (v >>> 8) & 32'hFFFF;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_st[k] = 0; m_g[k] = 0; m_ol[k] = 0; m_or[k] = 0;
        end
        m_pl = 0; m_pr = 0; m_tc = 0;
    endtask

    task automatic model_step();
        bit tick, chg, active;
        int ng;
        tick   = (m_tc == TD - 1);
        chg    = (int'(ndl) != m_pl) || (int'(ndr) != m_pr);
        active = (ndl != 0) || (ndr != 0);
        for (int k = 0; k < 2; k++) begin
            m_ol[k] = scale(inl, m_g[k]);
            m_or[k] = scale(inr, m_g[k]);
            if (m_st[k] == 0) begin
                m_g[k] = 0;
                if (chg && active) m_st[k] = 1;
            end else if (m_st[k] == 1 || m_st[k] == 2) begin
                if (chg) m_st[k] = 3;
                else if (tick && m_st[k] == 1) begin
                    ng = m_g[k] + atk[k];
                    if (ng >= 256) begin m_g[k] = 256; m_st[k] = 2; end
                    else m_g[k] = ng;
                end
`ifdef SUSTAIN_DECAY_EN
                else if (tick && m_st[k] == 2) begin
                    m_g[k] = (m_g[k] - 1 < 128) ? 128 : m_g[k] - 1;
                end
`endif
            end else begin
                if (tick) begin
                    ng = m_g[k] - 16;
                    if (ng <= 0) begin m_g[k] = 0; m_st[k] = active ? 1 : 0; end
                    else m_g[k] = ng;
                end
            end
        end
        m_tc = tick ? 0 : m_tc + 1;
        m_pl = int'(ndl);
        m_pr = int'(ndr);
    endtask

    // ---------------- checking ----------------
    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        check_val("left0",  int'(outl0), m_ol[0]);
        check_val("right0", int'(outr0), m_or[0]);
        check_val("state0", int'(st0),   m_st[0]);
        check_val("left7",  int'(outl1), m_ol[1]);
        check_val("right7", int'(outr1), m_or[1]);
        check_val("state7", int'(st1),   m_st[1]);
    endtask

    // One clock: model advances on the same inputs the DUT samples.
    task automatic step();
        if (rst_n) model_step();
        else model_reset();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic run(input int n, input bit rnd);
        for (int i = 0; i < n; i++) begin
            if (rnd) begin
                inl = 16'($urandom);
                inr = 16'($urandom);
            end
            step();
        end
    endtask

    // Asynchronous reset mid-cycle; outputs must clear before any edge.
    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        run(2, 1'b1);
        rst_n = 1'b1;
    endtask

    int g_before;
    int budget;

    initial begin
        // Reset hold with a non-zero input sample.
        inl = 16'h4000;
        inr = 16'h4000;
        model_reset();
        run(3, 1'b0);
        check_val("rst_left",  int'(outl0), 0);
        check_val("rst_right", int'(outr0), 0);
        check_val("rst_state", int'(st0),   0);
        @(negedge clk);
        rst_n = 1'b1;

        // Attack from rest to unity gain.
        run(3, 1'b1);
        inl = 16'd16384;
        ndl = 22'd191112;
        step();
        check_val("atk_enter", int'(st0), 1);
        run(140, 1'b0);
        check_val("sus_state", int'(st0), 2);
        check_val("sus_unity", int'(outl0), 16384);
        run(12, 1'b0);
        check_val("atk7_sus", int'(st1), 2);
        run(40, 1'b1);

        // Retrigger in SUSTAIN: release to zero, then attack again.
        ndl = 22'd95556;
        step();
        check_val("retrig_rel", int'(st0), 3);
        budget = 100;
        while (st0 != 2'd1 && budget > 0) begin
            run(1, 1'b1);
            budget--;
        end
        check_val("retrig_atk", int'(st0), 1);
        run(200, 1'b1);

        // Rest: release to silence; changes during release are ignored.
        ndl = '0;
        ndr = '0;
        step();
        check_val("rest_rel", int'(st0), 3);
        run(15, 1'b1);
        ndr = 22'd12345;
        run(5, 1'b1);
        ndr = '0;
        budget = 100;
        while (st0 == 2'd3 && budget > 0) begin
            run(1, 1'b1);
            budget--;
        end
        check_val("rest_silent", int'(st0), 0);
        run(10, 1'b1);

        // Change coinciding with a tick in ATTACK.
        ndl = 22'd191112;
        run(20, 1'b1);
        budget = 8;
        while (m_tc != TD - 1 && budget > 0) begin
            run(1, 1'b1);
            budget--;
        end
        check_val("coll_phase", m_tc, TD - 1);
        check_val("coll_pre", int'(st0), 1);
        g_before = m_g[0];
        inl = 16'd16384;
        ndl = 22'd100000;
        step();
        check_val("coll_state", int'(st0), 3);
        step();
        check_val("coll_gain", int'(outl0), (16384 * g_before) >>> 8);
        run(100, 1'b1);

        // Reset in the middle of an attack ramp.
        ndl = 22'd191112;
        run(50, 1'b1);
        async_reset();
        run(20, 1'b1);

        // Randomized note activity and samples.
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                case ($urandom_range(0, 3))
                    0: ndl = '0;
                    1: ndl = 22'd191112;
                    2: ndl = 22'($urandom_range(1, 4194303));
                    default: ndr = 22'($urandom_range(0, 1) * 95556);
                endcase
            end
            if ($urandom_range(0, 799) == 0) async_reset();
            else run(1, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
